insight_core_event_monitor: RTL and testbench

INSIGHT_CORE_EVENT_MONITOR -- requirements
Module: insight_core_event_monitor

---
 rtl/insight_core_event_monitor.sv | 170 +++++++++++++++++
 tb/tb_insight_core_event_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/insight_core_event_monitor.sv
// insight_core_event_monitor: per-hart event counters (commits, exceptions,
// interrupts, optional mem-outstanding cycles), per-hart RUN/IDLE/HUNG/CEASED
// state tracking with a commit watchdog, and a single-port counter read.
// Optional feature: define INSIGHT_MON_OUTSTANDING_EN to build counter 3.
module insight_core_event_monitor #(
  parameter int NUM_HARTS  = 2,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 1024,
  localparam int HART_W    = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_HARTS-1:0]   commit,
  input  logic [NUM_HARTS-1:0]   exception,
  input  logic [NUM_HARTS-1:0]   interrupt_fire,
  input  logic [NUM_HARTS-1:0]   wfi,
  input  logic [NUM_HARTS-1:0]   cease,
  input  logic [NUM_HARTS-1:0]   load_outstanding,
  input  logic [NUM_HARTS-1:0]   store_outstanding,
  input  logic                   clr,
  input  logic                   rd_req,
  input  logic [HART_W-1:0]      rd_hart,
  input  logic [1:0]             rd_sel,
  output logic                   rd_valid,
  output logic [CNT_W-1:0]       rd_data,
  output logic [2*NUM_HARTS-1:0] hart_state,
  output logic [NUM_HARTS-1:0]   hung
);

  localparam int WD_W = $clog2(WDOG_LIMIT + 1);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IDLE   = 2'd1,
    HUNG   = 2'd2,
    CEASED = 2'd3
  } hart_state_e;

  hart_state_e      state_q   [NUM_HARTS];
  hart_state_e      state_d   [NUM_HARTS];
  logic [WD_W-1:0]  wdog_q    [NUM_HARTS];
  logic [WD_W-1:0]  wdog_d    [NUM_HARTS];
  logic [CNT_W-1:0] cnt_commit[NUM_HARTS];
  logic [CNT_W-1:0] cnt_exc   [NUM_HARTS];
  logic [CNT_W-1:0] cnt_irq   [NUM_HARTS];
  logic [CNT_W-1:0] rd_mux;

`ifdef INSIGHT_MON_OUTSTANDING_EN
  logic [CNT_W-1:0] cnt_mem   [NUM_HARTS];

  // Count cycles with any load or store in flight, saturating
  always_ff @(posedge clock) begin
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (reset || clr) begin
        cnt_mem[h] <= '0;
      end else if ((load_outstanding[h] || store_outstanding[h]) && cnt_mem[h] != '1) begin
        cnt_mem[h] <= cnt_mem[h] + 1'b1;
      end
    end
  end
`else
  logic unused_mem_inputs;
  assign unused_mem_inputs = ^{load_outstanding, store_outstanding};
`endif

  // Per-hart next state and watchdog; the watchdog only advances while the
  // hart stays in RUN without committing, so any exit from RUN clears it
  always_comb begin
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      state_d[h] = state_q[h];
      wdog_d[h]  = '0;
      if (cease[h]) begin
        state_d[h] = CEASED;
      end else begin
        case (state_q[h])
          RUN: begin
            if (wfi[h] && !commit[h])
              state_d[h] = IDLE;
            else if (!commit[h] && wdog_q[h] == WD_W'(WDOG_LIMIT - 1))
              state_d[h] = HUNG;
          end
          IDLE: begin
            if (interrupt_fire[h] || !wfi[h])
              state_d[h] = RUN;
          end
          HUNG: begin
            if (commit[h])
              state_d[h] = RUN;
            else if (wfi[h])
              state_d[h] = IDLE;
          end
          default: state_d[h] = CEASED;
        endcase
      end
      if (!clr && !commit[h] && state_q[h] == RUN && state_d[h] == RUN)
        wdog_d[h] = wdog_q[h] + 1'b1;
    end
  end

  // State and watchdog registers
  always_ff @(posedge clock) begin
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (reset) begin
        state_q[h] <= RUN;
        wdog_q[h]  <= '0;
      end else begin
        state_q[h] <= state_d[h];
        wdog_q[h]  <= wdog_d[h];
      end
    end
  end

  // Saturating event counters; clr wins over same-cycle events
  always_ff @(posedge clock) begin
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (reset || clr) begin
        cnt_commit[h] <= '0;
        cnt_exc[h]    <= '0;
        cnt_irq[h]    <= '0;
      end else begin
        if (commit[h] && cnt_commit[h] != '1)
          cnt_commit[h] <= cnt_commit[h] + 1'b1;
        if (exception[h] && cnt_exc[h] != '1)
          cnt_exc[h] <= cnt_exc[h] + 1'b1;
        if (interrupt_fire[h] && cnt_irq[h] != '1)
          cnt_irq[h] <= cnt_irq[h] + 1'b1;
      end
    end
  end

  // Read select; out-of-range hart indices match nothing and return zero
  always_comb begin
    rd_mux = '0;
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      if (rd_hart == HART_W'(h)) begin
        case (rd_sel)
          2'd0:    rd_mux = cnt_commit[h];
          2'd1:    rd_mux = cnt_exc[h];
          2'd2:    rd_mux = cnt_irq[h];
`ifdef INSIGHT_MON_OUTSTANDING_EN
          default: rd_mux = cnt_mem[h];
`else
          default: rd_mux = '0;
`endif
        endcase
      end
    end
  end

  // Read response register; data holds between reads
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req)
        rd_data <= rd_mux;
    end
  end

  // Pack registered per-hart state onto the outputs
  always_comb begin
    for (int unsigned h = 0; h < NUM_HARTS; h++) begin
      hart_state[2*h +: 2] = state_q[h];
      hung[h]              = (state_q[h] == HUNG);
    end
  end

endmodule

// File: tb/tb_insight_core_event_monitor.sv
// Directed bench for insight_core_event_monitor: 3 harts, 4-bit counters,
// watchdog limit 8. Expected values are hand computed.
module tb_insight_core_event_monitor;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] commit, exception, interrupt_fire, wfi, cease;
  logic [2:0] load_outstanding, store_outstanding;
  logic       clr, rd_req;
  logic [1:0] rd_hart, rd_sel;
  logic       rd_valid;
  logic [3:0] rd_data;
  logic [5:0] hart_state;
  logic [2:0] hung;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef INSIGHT_MON_OUTSTANDING_EN
  localparam logic [3:0] EXP_MEM = 4'd4;
`else
  localparam logic [3:0] EXP_MEM = 4'd0;
`endif

  insight_core_event_monitor #(
    .NUM_HARTS (3),
    .CNT_W     (4),
    .WDOG_LIMIT(8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .commit           (commit),
    .exception        (exception),
    .interrupt_fire   (interrupt_fire),
    .wfi              (wfi),
    .cease            (cease),
    .load_outstanding (load_outstanding),
    .store_outstanding(store_outstanding),
    .clr              (clr),
    .rd_req           (rd_req),
    .rd_hart          (rd_hart),
    .rd_sel           (rd_sel),
    .rd_valid         (rd_valid),
    .rd_data          (rd_data),
    .hart_state       (hart_state),
    .hung             (hung)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; commit = '0; exception = '0; interrupt_fire = '0;
    wfi = '0; cease = '0; load_outstanding = '0; store_outstanding = '0;
    clr = 1'b0; rd_req = 1'b0; rd_hart = '0; rd_sel = '0;
    tick(); tick();
    check("rst_state", 32'(hart_state), 32'h0);
    check("rst_hung", 32'(hung), 32'h0);
    check("rst_valid", 32'(rd_valid), 32'h0);
    check("rst_data", 32'(rd_data), 32'h0);

    // park all harts in IDLE
    reset = 1'b0; wfi = 3'b111;
    tick();
    check("idle_state", 32'(hart_state), 32'b010101);

    // five commits on hart 0
    for (int i = 0; i < 5; i++) begin
      commit = 3'b001; tick();
      commit = 3'b000; tick();
    end
    rd_req = 1'b1; rd_hart = 2'd0; rd_sel = 2'd0;
    tick();
    rd_req = 1'b0;
    check("rd5_valid", 32'(rd_valid), 32'h1);
    check("rd5_data", 32'(rd_data), 32'd5);
    tick();
    check("rd5_valid_drop", 32'(rd_valid), 32'h0);
    check("rd5_data_hold", 32'(rd_data), 32'd5);

    // 20 exceptions saturate a 4-bit counter at 15
    exception = 3'b001;
    repeat (20) tick();
    exception = 3'b000;
    rd_req = 1'b1; rd_sel = 2'd1;
    tick();
    rd_req = 1'b0;
    check("exc_sat", 32'(rd_data), 32'd15);

    // hart 2: simultaneous commit+exception+interrupt, then one more commit
    commit = 3'b100; exception = 3'b100; interrupt_fire = 3'b100;
    tick();
    exception = 3'b000; interrupt_fire = 3'b000;
    tick();
    commit = 3'b000;
    // back-to-back reads: commits=2, exc=1, irq=1, bad hart=0
    rd_req = 1'b1; rd_hart = 2'd2; rd_sel = 2'd0;
    tick();
    check("b2b0_valid", 32'(rd_valid), 32'h1);
    check("b2b0_data", 32'(rd_data), 32'd2);
    rd_sel = 2'd1;
    tick();
    check("b2b1_valid", 32'(rd_valid), 32'h1);
    check("b2b1_data", 32'(rd_data), 32'd1);
    rd_sel = 2'd2;
    tick();
    check("b2b2_data", 32'(rd_data), 32'd1);
    rd_hart = 2'd3; rd_sel = 2'd0;
    tick();
    rd_req = 1'b0;
    check("badhart_valid", 32'(rd_valid), 32'h1);
    check("badhart_data", 32'(rd_data), 32'd0);
    tick();
    check("b2b_end_valid", 32'(rd_valid), 32'h0);
    check("h2_back_idle", 32'(hart_state), 32'b010101);

    // watchdog on hart 1
    wfi = 3'b101;
    tick();
    check("h1_run", 32'(hart_state[3:2]), 32'd0);
    repeat (7) tick();
    check("wd7_hung", 32'(hung), 32'b000);
    check("wd7_state", 32'(hart_state[3:2]), 32'd0);
    tick();
    check("wd8_hung", 32'(hung), 32'b010);
    check("wd8_state", 32'(hart_state[3:2]), 32'd2);
    commit = 3'b010;
    tick();
    commit = 3'b000;
    check("unhung", 32'(hung), 32'b000);
    check("unhung_state", 32'(hart_state[3:2]), 32'd0);
    wfi = 3'b111;
    tick();
    check("h1_idle", 32'(hart_state[3:2]), 32'd1);

    // clr with same-cycle commit and read
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_keeps_state", 32'(hart_state), 32'b010101);
    for (int i = 0; i < 3; i++) begin
      commit = 3'b001; tick();
      commit = 3'b000; tick();
    end
    clr = 1'b1; commit = 3'b001; rd_req = 1'b1; rd_hart = 2'd0; rd_sel = 2'd0;
    tick();
    clr = 1'b0; commit = 3'b000;
    check("clr_rd_pre", 32'(rd_data), 32'd3);
    tick();
    check("clr_rd_post", 32'(rd_data), 32'd0);
    rd_sel = 2'd1;
    tick();
    rd_req = 1'b0;
    check("clr_exc", 32'(rd_data), 32'd0);

    // load and store outstanding together for 4 cycles
    load_outstanding = 3'b001; store_outstanding = 3'b001;
    repeat (4) tick();
    load_outstanding = 3'b000; store_outstanding = 3'b000;
    rd_req = 1'b1; rd_sel = 2'd3;
    tick();
    rd_req = 1'b0;
    check("mem_cnt", 32'(rd_data), 32'(EXP_MEM));

    // cease wins over wfi, and is sticky
    cease = 3'b100;
    tick();
    cease = 3'b000;
    check("ceased", 32'(hart_state[5:4]), 32'd3);
    interrupt_fire = 3'b100; wfi = 3'b000;
    tick();
    interrupt_fire = 3'b000;
    check("ceased_sticky", 32'(hart_state), 32'b110000);

    // reset together with a read: no response, everything back to reset
    rd_req = 1'b1; rd_hart = 2'd2; rd_sel = 2'd1; reset = 1'b1;
    tick();
    rd_req = 1'b0; reset = 1'b0; wfi = 3'b111;
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_rd_data", 32'(rd_data), 32'h0);
    check("rst2_state", 32'(hart_state), 32'h0);
    tick();
    check("rst2_no_valid", 32'(rd_valid), 32'h0);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    check("rst_cnt_zero_valid", 32'(rd_valid), 32'h1);
    check("rst_cnt_zero", 32'(rd_data), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
